// File: rtl/s27_bist_pkg.sv
// Shared types and constants for the s27 BIST controller and its MISR.
// Pattern/signature widths, LFSR taps and MISR polynomial live here so harnesses agree.
package s27_bist_pkg;

    localparam int PAT_W = 4;
    localparam int SIG_W = 8;

    // Feedback taps on l[3] and l[2]: polynomial x^4+x^3+1, period 15.
    localparam logic [PAT_W-1:0] LFSR_TAPS = 4'b1100;
    localparam logic [SIG_W-1:0] MISR_POLY = 8'h1D;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        INIT   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    function automatic logic [PAT_W-1:0] lfsr_step(input logic [PAT_W-1:0] l);
        return {l[PAT_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] m, input logic d);
        return {m[SIG_W-2:0], 1'b0} ^ (m[SIG_W-1] ? MISR_POLY : '0) ^ {{(SIG_W-1){1'b0}}, d};
    endfunction

endpackage

// File: rtl/s27_bist_misr.sv
// 8-bit MISR compacting a 1-bit response stream; clear has priority over enable.
// Zero latency from din to state update at the next edge; no backpressure.
module s27_bist_misr
    import s27_bist_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= misr_step(sig, din);
        end
    end

endmodule

// File: rtl/s27_bist_ctrl.sv
// BIST tester for s27: LFSR patterns on G0..G3, MISR compaction of G17, golden compare.
// RESP is captured in the same cycle its PAT is presented; START is ignored unless IDLE.
module s27_bist_ctrl
    import s27_bist_pkg::*;
#(
    parameter int unsigned      NUM_PATTERNS = 64,
    parameter int unsigned      INIT_CYCLES  = 4,
    parameter logic [PAT_W-1:0] INIT_VECTOR  = 4'b0000,
    parameter logic [PAT_W-1:0] LFSR_SEED    = 4'b1001,
    parameter logic [SIG_W-1:0] GOLDEN_SIG   = 8'h00
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    output logic [PAT_W-1:0] PAT,
    input  logic             RESP,
    output logic             BUSY,
    output logic             DONE,
    output logic [SIG_W-1:0] SIGNATURE,
    output logic             PASS
);

    // An all-zero seed would lock the LFSR, so it is replaced.
    localparam logic [PAT_W-1:0] SEED      = (LFSR_SEED == '0) ? 4'b0001 : LFSR_SEED;
    localparam int               ICW       = (INIT_CYCLES > 0) ? $clog2(INIT_CYCLES + 1) : 1;
    localparam logic [ICW-1:0]   INIT_LAST = ICW'((INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0);
    localparam logic [15:0]      RUN_LAST  = 16'(NUM_PATTERNS - 1);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] lfsr_q, lfsr_d;
    logic [ICW-1:0]   init_cnt_q, init_cnt_d;
    logic [15:0]      pat_cnt_q, pat_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             misr_clr;
    logic             misr_en;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            pat_q      <= '0;
            lfsr_q     <= SEED;
            init_cnt_q <= '0;
            pat_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pat_q      <= pat_d;
            lfsr_q     <= lfsr_d;
            init_cnt_q <= init_cnt_d;
            pat_cnt_q  <= pat_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        lfsr_d     = lfsr_q;
        init_cnt_d = init_cnt_q;
        pat_cnt_d  = pat_cnt_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        misr_clr   = 1'b0;
        misr_en    = 1'b0;

        if (ABORT) begin
            // Signature is left at its partial value for post-mortem inspection.
            state_d = IDLE;
            pat_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (START) begin
                        done_d     = 1'b0;
                        pass_d     = 1'b0;
                        misr_clr   = 1'b1;
                        lfsr_d     = SEED;
                        busy_d     = 1'b1;
                        init_cnt_d = '0;
                        pat_cnt_d  = '0;
                        if (INIT_CYCLES == 0) begin
                            state_d = RUN;
                            pat_d   = SEED;
                        end else begin
                            state_d = INIT;
                            pat_d   = INIT_VECTOR;
                        end
                    end
                end
                INIT: begin
                    if (init_cnt_q == INIT_LAST) begin
                        state_d = RUN;
                        pat_d   = lfsr_q;
                    end else begin
                        init_cnt_d = init_cnt_q + ICW'(1);
                    end
                end
                RUN: begin
                    misr_en = 1'b1;
                    lfsr_d  = lfsr_step(lfsr_q);
                    if (pat_cnt_q == RUN_LAST) begin
                        state_d = FINISH;
                        pat_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        // Compare against the value the MISR takes on this same edge.
                        pass_d  = (misr_step(SIGNATURE, RESP) == GOLDEN_SIG);
                    end else begin
                        pat_cnt_d = pat_cnt_q + 16'd1;
                        pat_d     = lfsr_step(lfsr_q);
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    s27_bist_misr u_misr (
        .clk (CK),
        .rst (RST),
        .clr (misr_clr),
        .en  (misr_en),
        .din (RESP),
        .sig (SIGNATURE)
    );

    assign PAT  = pat_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign PASS = pass_q;

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Directed bench for s27_bist_ctrl: four parameterisations, one closed around an s27 model.
// Inputs are driven and outputs sampled on the falling edge of CK.
module tb_s27_bist_ctrl;

    logic CK  = 1'b0;
    logic RST = 1'b1;
    always #5 CK = ~CK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CK);
    endtask

    // s27 core: state {G7,G6,G5}; returns {G17, next state}. f forces G11 stuck-at-0.
    function automatic logic [3:0] s27_step(input logic [2:0] st, input logic [3:0] g, input logic f);
        logic g5, g6, g7, g8, g9, g10, g11, g12, g13, g14, g15, g16;
        {g7, g6, g5} = st;
        g14 = ~g[0];
        g8  = g14 & g6;
        g12 = ~(g[1] | g7);
        g15 = g12 | g8;
        g16 = g[3] | g8;
        g9  = ~(g16 & g15);
        g11 = f ? 1'b0 : ~(g5 | g9);
        g10 = ~(g14 | g11);
        g13 = ~(g[2] | g12);
        return {~g11, g13, g11, g10};
    endfunction

    // Reference for the default configuration: 4 INIT cycles of 0000, then 64 LFSR patterns.
    function automatic logic [7:0] calc_sig(input logic f);
        logic [2:0] st;
        logic [3:0] l;
        logic [7:0] m;
        logic [3:0] r;
        st = 3'b000;
        l  = 4'b1001;
        m  = 8'h00;
        for (int i = 0; i < 4; i++) begin
            r  = s27_step(st, 4'b0000, f);
            st = r[2:0];
        end
        for (int k = 0; k < 64; k++) begin
            r  = s27_step(st, l, f);
            m  = {m[6:0], 1'b0} ^ (m[7] ? 8'h1D : 8'h00) ^ {7'b0, r[3]};
            st = r[2:0];
            l  = {l[2:0], l[3] ^ l[2]};
        end
        return m;
    endfunction

    localparam logic [7:0] GOLD = calc_sig(1'b0);

    // Instance A: no INIT, 5 patterns
    logic       start_a = 1'b0, abort_a = 1'b0, resp_a = 1'b0;
    logic [3:0] pat_a;
    logic       busy_a, done_a, pass_a;
    logic [7:0] sig_a;

    s27_bist_ctrl #(.NUM_PATTERNS(5), .INIT_CYCLES(0), .INIT_VECTOR(4'b0000),
                    .LFSR_SEED(4'b1001), .GOLDEN_SIG(8'h00)) u_a (
        .CK(CK), .RST(RST), .START(start_a), .ABORT(abort_a), .PAT(pat_a),
        .RESP(resp_a), .BUSY(busy_a), .DONE(done_a), .SIGNATURE(sig_a), .PASS(pass_a));

    // Instance B: no INIT, 3 patterns, golden 8'h07
    logic       start_b = 1'b0, resp_b = 1'b0;
    logic [3:0] pat_b;
    logic       busy_b, done_b, pass_b;
    logic [7:0] sig_b;

    s27_bist_ctrl #(.NUM_PATTERNS(3), .INIT_CYCLES(0), .INIT_VECTOR(4'b0000),
                    .LFSR_SEED(4'b1001), .GOLDEN_SIG(8'h07)) u_b (
        .CK(CK), .RST(RST), .START(start_b), .ABORT(1'b0), .PAT(pat_b),
        .RESP(resp_b), .BUSY(busy_b), .DONE(done_b), .SIGNATURE(sig_b), .PASS(pass_b));

    // Instance C: 4 INIT cycles of 1111, 6 patterns
    logic       start_c = 1'b0, resp_c = 1'b0;
    logic [3:0] pat_c;
    logic       busy_c, done_c, pass_c;
    logic [7:0] sig_c;

    s27_bist_ctrl #(.NUM_PATTERNS(6), .INIT_CYCLES(4), .INIT_VECTOR(4'b1111),
                    .LFSR_SEED(4'b1001), .GOLDEN_SIG(8'h00)) u_c (
        .CK(CK), .RST(RST), .START(start_c), .ABORT(1'b0), .PAT(pat_c),
        .RESP(resp_c), .BUSY(busy_c), .DONE(done_c), .SIGNATURE(sig_c), .PASS(pass_c));

    // Instance D: default parameters closed around the s27 model
    logic       start_d = 1'b0, fault = 1'b0;
    logic [3:0] pat_d;
    logic       busy_d, done_d, pass_d, resp_d;
    logic [7:0] sig_d;
    logic [2:0] s27_st;
    logic [3:0] s27_r;

    assign s27_r  = s27_step(s27_st, pat_d, fault);
    assign resp_d = s27_r[3];

    always @(posedge CK or posedge RST) begin
        if (RST) s27_st <= 3'b000;
        else     s27_st <= s27_r[2:0];
    end

    s27_bist_ctrl #(.GOLDEN_SIG(GOLD)) u_d (
        .CK(CK), .RST(RST), .START(start_d), .ABORT(1'b0), .PAT(pat_d),
        .RESP(resp_d), .BUSY(busy_d), .DONE(done_d), .SIGNATURE(sig_d), .PASS(pass_d));

    task automatic run_d(output int cyc);
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        cyc = 0;
        while (!done_d && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        logic [3:0] exp_pat [5];
        int busy_n, init_n, init_bad, cyc;
        exp_pat = '{4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010};

        // Reset state
        tick();
        chk("rst_pat", pat_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_sig", sig_a, 0);
        RST = 1'b0;

        // Pattern order with no INIT phase
        tick();
        start_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            start_a = 1'b0;
            chk($sformatf("a_pat%0d", k), pat_a, exp_pat[k]);
            chk($sformatf("a_busy%0d", k), busy_a, 1);
            chk($sformatf("a_done%0d", k), done_a, 0);
        end
        tick();
        chk("a_fin_pat", pat_a, 0);
        chk("a_fin_busy", busy_a, 0);
        chk("a_fin_done", done_a, 1);
        chk("a_fin_pass", pass_a, 1);
        chk("a_fin_sig", sig_a, 0);

        // START in FINISH is ignored; held into IDLE it is accepted
        start_a = 1'b1;
        tick();
        chk("a_finstart_busy", busy_a, 0);
        chk("a_finstart_done", done_a, 1);
        tick();
        chk("a_restart_pat", pat_a, 4'b1001);
        chk("a_restart_done", done_a, 0);
        resp_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("a_busystart_pat", pat_a, 4'b0011);
        tick();
        chk("a_cyc2_pat", pat_a, 4'b0110);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("a_abort_busy", busy_a, 0);
        chk("a_abort_pat", pat_a, 0);
        chk("a_abort_done", done_a, 0);
        chk("a_abort_sig", sig_a, 8'h03);
        tick();
        chk("a_abort_idle", busy_a, 0);
        start_a = 1'b1;
        abort_a = 1'b1;
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        chk("a_coll_busy", busy_a, 0);
        chk("a_coll_pat", pat_a, 0);
        tick();
        chk("a_coll_busy2", busy_a, 0);

        // Reset in the middle of RUN takes effect immediately
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        chk("a_mid_sig", sig_a, 8'h01);
        #2 RST = 1'b1;
        #1;
        chk("a_mrst_pat", pat_a, 0);
        chk("a_mrst_busy", busy_a, 0);
        chk("a_mrst_done", done_a, 0);
        chk("a_mrst_pass", pass_a, 0);
        chk("a_mrst_sig", sig_a, 0);
        start_a = 1'b1;
        tick();
        tick();
        chk("a_rststart_busy", busy_a, 0);
        start_a = 1'b0;
        RST = 1'b0;
        tick();
        chk("a_postrst_busy", busy_a, 0);
        chk("a_postrst_pat", pat_a, 0);
        resp_a = 1'b0;

        // Compaction: RESP=1 for 3 patterns gives 07; RESP=0 gives 00
        resp_b  = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        repeat (3) tick();
        chk("b_one_sig", sig_b, 8'h07);
        chk("b_one_done", done_b, 1);
        chk("b_one_pass", pass_b, 1);
        tick();
        resp_b  = 1'b0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_clr_done", done_b, 0);
        chk("b_clr_pass", pass_b, 0);
        repeat (3) tick();
        chk("b_zero_sig", sig_b, 8'h00);
        chk("b_zero_done", done_b, 1);
        chk("b_zero_pass", pass_b, 0);

        // INIT phase with toggling RESP
        busy_n   = 0;
        init_n   = 0;
        init_bad = 0;
        start_c  = 1'b1;
        resp_c   = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick();
            start_c = 1'b0;
            if (busy_c) busy_n++;
            if (pat_c == 4'b1111) begin
                init_n++;
                if (sig_c != 8'h00) init_bad++;
            end
            if (i == 5) chk("c_first_run_pat", pat_c, 4'b1001);
            resp_c = i[0];
        end
        chk("c_busy_cycles", busy_n, 10);
        chk("c_init_cycles", init_n, 4);
        chk("c_init_sig_nonzero", init_bad, 0);
        chk("c_sig", sig_c, 8'h2A);
        chk("c_done", done_c, 1);

        // Closed loop with s27, fault-free then G11 stuck-at-0
        run_d(cyc);
        chk("d_latency", cyc, 68);
        chk("d_done", done_d, 1);
        chk("d_sig", sig_d, GOLD);
        chk("d_pass", pass_d, 1);
        fault = 1'b1;
        RST   = 1'b1;
        tick();
        RST   = 1'b0;
        tick();
        run_d(cyc);
        chk("d_f_done", done_d, 1);
        chk("d_f_sig", sig_d, calc_sig(1'b1));
        chk("d_f_pass", pass_d, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
